// File: rtl/stg3ex_mc.sv
// Execute stage: single-cycle ALU ops plus iterative (one bit per cycle) MUL/DIVU/REMU.
// Operand B may be an extended immediate or an LUI-held upper prefix joined to the immediate.
module stg3ex_mc #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned IMM_W  = DATA_W / 2,
  parameter int unsigned TGT_W  = 4
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_valid,
  output logic              ow_ready,
  input  logic [3:0]        iw_op,
  input  logic              iw_imm_en,
  input  logic              iw_sgn_en,
  input  logic [IMM_W-1:0]  iw_imm,
  input  logic [DATA_W-1:0] iw_a,
  input  logic [DATA_W-1:0] iw_b,
  input  logic [TGT_W-1:0]  iw_tgt,
  output logic              ow_valid,
  input  logic              iw_ready,
  output logic [DATA_W-1:0] ow_result,
  output logic [TGT_W-1:0]  ow_tgt,
  output logic              ow_wr_en,
  output logic [3:0]        ow_flags
);
  localparam int unsigned ShW  = $clog2(DATA_W);
  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] DataWVal = DATA_W'(DATA_W);
  localparam logic [CntW-1:0]   LastIter = CntW'(DATA_W - 1);

  localparam logic [3:0] OpMov = 4'd1, OpAdd = 4'd2, OpSub = 4'd3, OpAnd = 4'd4, OpOr = 4'd5;
  localparam logic [3:0] OpXor = 4'd6, OpShl = 4'd7, OpShr = 4'd8, OpShrs = 4'd9, OpCmp = 4'd10;
  localparam logic [3:0] OpLui = 4'd11, OpMul = 4'd12, OpDivu = 4'd13, OpRemu = 4'd14;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d, wr_en_q, wr_en_d, held_q, held_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [TGT_W-1:0]  tgt_q, tgt_d, mc_tgt_q, mc_tgt_d;
  logic [3:0]        flags_q, flags_d, mc_op_q, mc_op_d;
  logic [IMM_W-1:0]  upper_q, upper_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // wa: multiplicand / quotient, wb: multiplier / divisor, acc: product / remainder
  logic [DATA_W-1:0] wa_q, wa_d, wb_q, wb_d, acc_q, acc_d;

  logic              out_free, accept, op_single, op_multi, sh_big;
  logic [DATA_W-1:0] imm_ext, opb, alu_res, mc_res;
  logic [DATA_W:0]   sum, diff, rem_sh;
  logic [3:0]        alu_flags, mc_flags;
  logic [ShW-1:0]    shamt;

  assign out_free  = !valid_q || iw_ready;
  assign ow_ready  = (state_q == StIdle) && out_free;
  assign accept    = iw_valid && ow_ready;
  assign op_single = (iw_op >= OpMov) && (iw_op <= OpCmp);
  assign op_multi  = (iw_op >= OpMul) && (iw_op <= OpRemu);

  always_comb begin
    if (held_q)         imm_ext = {upper_q, iw_imm};
    else if (iw_sgn_en) imm_ext = {{(DATA_W-IMM_W){iw_imm[IMM_W-1]}}, iw_imm};
    else                imm_ext = {{(DATA_W-IMM_W){1'b0}}, iw_imm};
  end

  assign opb    = iw_imm_en ? imm_ext : iw_b;
  assign sum    = {1'b0, iw_a} + {1'b0, opb};
  assign diff   = {1'b0, iw_a} - {1'b0, opb};
  assign sh_big = (opb >= DataWVal);
  assign shamt  = opb[ShW-1:0];

  // Flags are packed {V,N,C,Z}
  always_comb begin
    alu_res = '0;
    case (iw_op)
      OpMov:        alu_res = opb;
      OpAdd:        alu_res = sum[DATA_W-1:0];
      OpSub, OpCmp: alu_res = diff[DATA_W-1:0];
      OpAnd:        alu_res = iw_a & opb;
      OpOr:         alu_res = iw_a | opb;
      OpXor:        alu_res = iw_a ^ opb;
      OpShl:        alu_res = sh_big ? '0 : (iw_a << shamt);
      OpShr:        alu_res = sh_big ? '0 : (iw_a >> shamt);
      OpShrs:       alu_res = sh_big ? {DATA_W{iw_a[DATA_W-1]}}
                                     : $unsigned($signed(iw_a) >>> shamt);
      default:      alu_res = '0;
    endcase
    alu_flags = {1'b0, alu_res[DATA_W-1], 1'b0, alu_res == '0};
    case (iw_op)
      OpAdd: begin
        alu_flags[1] = sum[DATA_W];
        alu_flags[3] = (iw_a[DATA_W-1] == opb[DATA_W-1]) && (alu_res[DATA_W-1] != iw_a[DATA_W-1]);
      end
      OpSub, OpCmp: begin
        alu_flags[1] = diff[DATA_W];
        alu_flags[3] = (iw_a[DATA_W-1] != opb[DATA_W-1]) && (alu_res[DATA_W-1] != iw_a[DATA_W-1]);
      end
      OpShl, OpShr, OpShrs: alu_flags[3] = sh_big;
      default: ;
    endcase
  end

  // Divisor stays untouched during division, so wb_q == 0 still flags divide-by-zero at the end
  always_comb begin
    mc_res   = (mc_op_q == OpDivu) ? wa_q : acc_q;
    mc_flags = {(mc_op_q != OpMul) && (wb_q == '0), mc_res[DATA_W-1], 1'b0, mc_res == '0};
  end

  assign rem_sh = {acc_q, wa_q[DATA_W-1]};

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    result_d = result_q;
    tgt_d    = tgt_q;
    wr_en_d  = wr_en_q;
    flags_d  = flags_q;
    upper_d  = upper_q;
    held_d   = held_q;
    cnt_d    = cnt_q;
    mc_op_d  = mc_op_q;
    mc_tgt_d = mc_tgt_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    acc_d    = acc_q;
    if (valid_q && iw_ready) valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (iw_op == OpLui) begin
            upper_d = iw_imm;
            held_d  = 1'b1;
          end else if (iw_imm_en && (op_single || op_multi)) begin
            held_d = 1'b0;
          end
          if (op_single) begin
            valid_d  = 1'b1;
            result_d = alu_res;
            tgt_d    = iw_tgt;
            wr_en_d  = (iw_op != OpCmp);
            flags_d  = alu_flags;
          end
          if (op_multi) begin
            state_d  = StBusy;
            mc_op_d  = iw_op;
            mc_tgt_d = iw_tgt;
            wa_d     = iw_a;
            wb_d     = opb;
            acc_d    = '0;
            cnt_d    = '0;
          end
        end
      end
      StBusy: begin
        if (mc_op_q == OpMul) begin
          if (wb_q[0]) acc_d = acc_q + wa_q;
          wa_d = wa_q << 1;
          wb_d = wb_q >> 1;
        end else if (rem_sh >= {1'b0, wb_q}) begin
          acc_d = rem_sh[DATA_W-1:0] - wb_q;
          wa_d  = {wa_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[DATA_W-1:0];
          wa_d  = {wa_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIter) state_d = StDone;
      end
      StDone: begin
        if (out_free) begin
          valid_d  = 1'b1;
          result_d = mc_res;
          tgt_d    = mc_tgt_q;
          wr_en_d  = 1'b1;
          flags_d  = mc_flags;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      result_q <= '0;
      tgt_q    <= '0;
      wr_en_q  <= 1'b0;
      flags_q  <= '0;
      upper_q  <= '0;
      held_q   <= 1'b0;
      cnt_q    <= '0;
      mc_op_q  <= '0;
      mc_tgt_q <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      tgt_q    <= tgt_d;
      wr_en_q  <= wr_en_d;
      flags_q  <= flags_d;
      upper_q  <= upper_d;
      held_q   <= held_d;
      cnt_q    <= cnt_d;
      mc_op_q  <= mc_op_d;
      mc_tgt_q <= mc_tgt_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      acc_q    <= acc_d;
    end
  end

  assign ow_valid  = valid_q;
  assign ow_result = result_q;
  assign ow_tgt    = tgt_q;
  assign ow_wr_en  = wr_en_q;
  assign ow_flags  = flags_q;

endmodule

// File: tb/tb_stg3ex_mc.sv
// Directed bench for stg3ex_mc at DATA_W=24: hand-computed vectors checked by immediate asserts.
module tb_stg3ex_mc;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned IMM_W  = 12;
  localparam int unsigned TGT_W  = 4;

  localparam logic [3:0] OpMov = 4'd1, OpAdd = 4'd2, OpSub = 4'd3, OpAnd = 4'd4;
  localparam logic [3:0] OpShl = 4'd7, OpShr = 4'd8, OpShrs = 4'd9, OpCmp = 4'd10;
  localparam logic [3:0] OpLui = 4'd11, OpMul = 4'd12, OpDivu = 4'd13, OpRemu = 4'd14;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              iw_valid = 1'b0;
  logic              ow_ready;
  logic [3:0]        iw_op = '0;
  logic              iw_imm_en = 1'b0;
  logic              iw_sgn_en = 1'b0;
  logic [IMM_W-1:0]  iw_imm = '0;
  logic [DATA_W-1:0] iw_a = '0;
  logic [DATA_W-1:0] iw_b = '0;
  logic [TGT_W-1:0]  iw_tgt = '0;
  logic              ow_valid;
  logic              iw_ready = 1'b1;
  logic [DATA_W-1:0] ow_result;
  logic [TGT_W-1:0]  ow_tgt;
  logic              ow_wr_en;
  logic [3:0]        ow_flags;

  int checks = 0;
  int errors = 0;
  int busy_rdy_bad = 0;
  int cyc = 0;
  int stray_valid = 0;

  stg3ex_mc #(.DATA_W(DATA_W), .IMM_W(IMM_W), .TGT_W(TGT_W)) dut (
    .iw_clk    (clk),
    .iw_rst_n  (rst_n),
    .iw_valid  (iw_valid),
    .ow_ready  (ow_ready),
    .iw_op     (iw_op),
    .iw_imm_en (iw_imm_en),
    .iw_sgn_en (iw_sgn_en),
    .iw_imm    (iw_imm),
    .iw_a      (iw_a),
    .iw_b      (iw_b),
    .iw_tgt    (iw_tgt),
    .ow_valid  (ow_valid),
    .iw_ready  (iw_ready),
    .ow_result (ow_result),
    .ow_tgt    (ow_tgt),
    .ow_wr_en  (ow_wr_en),
    .ow_flags  (ow_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                       input logic imm_en, input logic sgn_en, input logic [11:0] imm,
                       input logic [3:0] tgt);
    iw_valid  = 1'b1;
    iw_op     = op;
    iw_a      = a;
    iw_b      = b;
    iw_imm_en = imm_en;
    iw_sgn_en = sgn_en;
    iw_imm    = imm;
    iw_tgt    = tgt;
  endtask

  task automatic idle();
    iw_valid  = 1'b0;
    iw_imm_en = 1'b0;
    iw_sgn_en = 1'b0;
  endtask

  // Counts edges until ow_valid rises, bounded; also counts busy cycles with ow_ready high
  task automatic wait_valid(output int n);
    n = 0;
    busy_rdy_bad = 0;
    while (ow_valid !== 1'b1 && n < 40) begin
      if (ow_ready !== 1'b0) busy_rdy_bad++;
      tick();
      n++;
    end
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", ow_valid, 1'b0);
    chk("rst_result", ow_result, 24'h0);
    chk("rst_tgt", ow_tgt, 4'h0);
    chk("rst_wr_en", ow_wr_en, 1'b0);
    chk("rst_flags", ow_flags, 4'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", ow_ready, 1'b1);

    issue(OpAdd, 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 12'h0, 4'd3);
    tick();
    idle();
    chk("add_valid", ow_valid, 1'b1);
    chk("add_result", ow_result, 24'h000000);
    chk("add_flags", ow_flags, 4'b0011);
    chk("add_tgt", ow_tgt, 4'd3);
    chk("add_wr_en", ow_wr_en, 1'b1);
    tick();
    chk("add_drain", ow_valid, 1'b0);

    issue(OpLui, 24'h0, 24'h0, 1'b0, 1'b0, 12'hABC, 4'd0);
    tick();
    idle();
    chk("lui_novalid", ow_valid, 1'b0);
    chk("lui_flags_keep", ow_flags, 4'b0011);
    issue(OpAdd, 24'h0, 24'h00000F, 1'b1, 1'b0, 12'h123, 4'd4);
    tick();
    chk("lui_join", ow_result, 24'hABC123);
    chk("lui_join_flags", ow_flags, 4'b0100);
    issue(OpAdd, 24'h0, 24'h00000F, 1'b1, 1'b1, 12'hFFF, 4'd5);
    tick();
    chk("sgn_ext", ow_result, 24'hFFFFFF);
    issue(OpMov, 24'h0, 24'h00000F, 1'b1, 1'b0, 12'hFFF, 4'd5);
    tick();
    chk("zero_ext", ow_result, 24'h000FFF);
    issue(OpLui, 24'h0, 24'h0, 1'b0, 1'b0, 12'h111, 4'd0);
    tick();
    issue(OpLui, 24'h0, 24'h0, 1'b0, 1'b0, 12'h222, 4'd0);
    tick();
    issue(OpAdd, 24'h0, 24'h0, 1'b1, 1'b0, 12'h333, 4'd1);
    tick();
    chk("lui_overwrite", ow_result, 24'h222333);

    issue(OpSub, 24'h000005, 24'h000007, 1'b0, 1'b0, 12'h0, 4'd6);
    tick();
    chk("sub_result", ow_result, 24'hFFFFFE);
    chk("sub_flags", ow_flags, 4'b0110);
    issue(OpCmp, 24'h7FFFFF, 24'hFFFFFF, 1'b0, 1'b0, 12'h0, 4'd7);
    tick();
    chk("cmp_valid", ow_valid, 1'b1);
    chk("cmp_flags", ow_flags, 4'b1110);
    chk("cmp_wr_en", ow_wr_en, 1'b0);
    issue(OpShrs, 24'h800000, 24'd30, 1'b0, 1'b0, 12'h0, 4'd2);
    tick();
    chk("shrs_result", ow_result, 24'hFFFFFF);
    chk("shrs_flags", ow_flags, 4'b1100);
    issue(OpShl, 24'h000001, 24'd23, 1'b0, 1'b0, 12'h0, 4'd2);
    tick();
    chk("shl_result", ow_result, 24'h800000);
    chk("shl_flags", ow_flags, 4'b0100);
    issue(OpShr, 24'h800000, 24'd24, 1'b0, 1'b0, 12'h0, 4'd2);
    tick();
    chk("shr_big_result", ow_result, 24'h000000);
    chk("shr_big_flags", ow_flags, 4'b1001);
    issue(OpAnd, 24'hF0F0F0, 24'h0F0F0F, 1'b0, 1'b0, 12'h0, 4'd2);
    tick();
    idle();
    chk("and_flags", ow_flags, 4'b0001);
    tick();

    issue(OpMul, 24'd1000, 24'd3000, 1'b0, 1'b0, 12'h0, 4'd9);
    tick();
    idle();
    iw_a   = 24'h123456;
    iw_b   = 24'h000002;
    iw_tgt = 4'd0;
    wait_valid(cyc);
    chk("mul_latency", cyc, 25);
    chk("mul_busy_ready", busy_rdy_bad, 0);
    chk("mul_result", ow_result, 24'h2DC6C0);
    chk("mul_flags", ow_flags, 4'b0000);
    chk("mul_tgt", ow_tgt, 4'd9);
    tick();
    chk("mul_drain", ow_valid, 1'b0);

    issue(OpDivu, 24'd100, 24'd0, 1'b0, 1'b0, 12'h0, 4'd10);
    tick();
    idle();
    wait_valid(cyc);
    chk("div0_latency", cyc, 25);
    chk("div0_result", ow_result, 24'hFFFFFF);
    chk("div0_flags", ow_flags, 4'b1100);
    tick();
    issue(OpRemu, 24'd100, 24'd7, 1'b0, 1'b0, 12'h0, 4'd11);
    tick();
    idle();
    wait_valid(cyc);
    chk("remu_result", ow_result, 24'd2);
    chk("remu_flags", ow_flags, 4'b0000);
    tick();
    issue(OpDivu, 24'd100, 24'd7, 1'b0, 1'b0, 12'h0, 4'd12);
    tick();
    idle();
    wait_valid(cyc);
    chk("divu_result", ow_result, 24'd14);
    tick();

    issue(OpAdd, 24'd1, 24'd1, 1'b0, 1'b0, 12'h0, 4'd1);
    tick();
    iw_ready = 1'b0;
    issue(OpAdd, 24'd2, 24'd2, 1'b0, 1'b0, 12'h0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_result", ow_result, 24'd2);
      chk("bp_hold_valid", ow_valid, 1'b1);
      chk("bp_hold_ready", ow_ready, 1'b0);
      chk("bp_hold_tgt", ow_tgt, 4'd1);
    end
    iw_ready = 1'b1;
    tick();
    chk("bp_second", ow_result, 24'd4);
    chk("bp_second_tgt", ow_tgt, 4'd2);
    issue(OpAdd, 24'd3, 24'd3, 1'b0, 1'b0, 12'h0, 4'd3);
    tick();
    idle();
    chk("bp_third", ow_result, 24'd6);
    chk("bp_third_tgt", ow_tgt, 4'd3);
    tick();
    chk("bp_drain", ow_valid, 1'b0);

    issue(OpLui, 24'h0, 24'h0, 1'b0, 1'b0, 12'h555, 4'd0);
    tick();
    issue(OpSub, 24'd5, 24'd7, 1'b0, 1'b0, 12'h0, 4'd6);
    tick();
    idle();
    tick();
    issue(OpMul, 24'd5, 24'd5, 1'b0, 1'b0, 12'h0, 4'd8);
    tick();
    idle();
    repeat (10) tick();
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", ow_valid, 1'b0);
    chk("mrst_result", ow_result, 24'h0);
    chk("mrst_tgt", ow_tgt, 4'h0);
    chk("mrst_wr_en", ow_wr_en, 1'b0);
    chk("mrst_flags", ow_flags, 4'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_ready", ow_ready, 1'b1);
    stray_valid = 0;
    for (int i = 0; i < 30; i++) begin
      if (ow_valid !== 1'b0) stray_valid++;
      tick();
    end
    chk("mrst_no_result", stray_valid, 0);
    issue(OpAdd, 24'h0, 24'h0, 1'b1, 1'b0, 12'h823, 4'd1);
    tick();
    idle();
    chk("mrst_held_clear", ow_result, 24'h000823);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
